// File: rtl/police_dispatch.sv
// police_dispatch: upstream stage of police_car.
// Counts corpse reports, waits a frame-counted delay, then holds on_call
// until police_car pulses complete. A cooldown follows each sweep, and
// corpses reported in the meantime cause a new dispatch.
// Optional feature macro: POLICE_WITNESS_EN adds the witness_call input.
// A witness call in IDLE or REPORTED skips the remaining delay.
module police_dispatch #(
    parameter int DISPATCH_DELAY = 120,
    parameter int COOLDOWN       = 180,
    parameter int TIMER_W        = 10,
    parameter int CNT_W          = 4
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_clk,
    input  logic               corpse_found,
    input  logic               complete,
`ifdef POLICE_WITNESS_EN
    input  logic               witness_call,
`endif
    output logic               on_call,
    output logic [CNT_W-1:0]   pending_corpses,
    output logic [TIMER_W-1:0] countdown,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        REPORTED   = 2'd1,
        DISPATCHED = 2'd2,
        COOLDN     = 2'd3
    } state_t;

    // A zero report delay still costs one frame.
    localparam logic [TIMER_W-1:0] DLY_LOAD  = (DISPATCH_DELAY < 1) ? TIMER_W'(1)
                                                                     : TIMER_W'(DISPATCH_DELAY);
    localparam logic [TIMER_W-1:0] COOL_LOAD = TIMER_W'(COOLDOWN);
    localparam logic [TIMER_W-1:0] ONE       = TIMER_W'(1);
    localparam logic [CNT_W-1:0]   PEND_MAX  = {CNT_W{1'b1}};

    state_t             state, state_nxt;
    logic [TIMER_W-1:0] cd_nxt;
    logic [CNT_W-1:0]   pend_nxt;
    logic               on_call_nxt, busy_nxt;
    logic               frame_q;
    logic               tick;
    logic               wit_take;

    logic [CNT_W:0]     pend_base;
    logic [CNT_W:0]     pend_sum;
    logic [1:0]         pend_inc;

    assign tick = frame_clk & ~frame_q;

`ifdef POLICE_WITNESS_EN
    // Witness calls only matter before the car has been sent.
    assign wit_take = witness_call & ((state == IDLE) | (state == REPORTED));
`else
    assign wit_take = 1'b0;
`endif

    // Pending count: a sweep completion clears first, then new reports add, saturating.
    always_comb begin
        pend_base = {1'b0, pending_corpses};
        if ((state == DISPATCHED) && complete)
            pend_base = '0;
        pend_inc = {1'b0, corpse_found} + {1'b0, wit_take};
        pend_sum = pend_base + {{(CNT_W-1){1'b0}}, pend_inc};
        if (pend_sum > {1'b0, PEND_MAX})
            pend_nxt = PEND_MAX;
        else
            pend_nxt = pend_sum[CNT_W-1:0];
    end

    // Next-state and countdown.
    always_comb begin
        state_nxt = state;
        cd_nxt    = countdown;
        unique case (state)
            IDLE: begin
                cd_nxt = '0;
                if (wit_take) begin
                    state_nxt = DISPATCHED;
                end else if (corpse_found) begin
                    // A same-cycle tick is not consumed by the fresh load.
                    state_nxt = REPORTED;
                    cd_nxt    = DLY_LOAD;
                end
            end
            REPORTED: begin
                if (wit_take) begin
                    state_nxt = DISPATCHED;
                    cd_nxt    = '0;
                end else if (tick) begin
                    if (countdown <= ONE) begin
                        state_nxt = DISPATCHED;
                        cd_nxt    = '0;
                    end else begin
                        cd_nxt = countdown - ONE;
                    end
                end
            end
            DISPATCHED: begin
                cd_nxt = '0;
                if (complete) begin
                    state_nxt = COOLDN;
                    cd_nxt    = COOL_LOAD;
                end
            end
            COOLDN: begin
                if (tick) begin
                    if (countdown <= ONE) begin
                        // Reports arriving on the leaving cycle still count.
                        if (pend_nxt != '0) begin
                            state_nxt = REPORTED;
                            cd_nxt    = DLY_LOAD;
                        end else begin
                            state_nxt = IDLE;
                            cd_nxt    = '0;
                        end
                    end else begin
                        cd_nxt = countdown - ONE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cd_nxt    = '0;
            end
        endcase
    end

    // Output decode from the upcoming state so the flops below hold them.
    always_comb begin
        on_call_nxt = (state_nxt == DISPATCHED);
        busy_nxt    = (state_nxt != IDLE);
    end

    // State, counters and registered outputs; reset drops everything at once.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state           <= IDLE;
            frame_q         <= 1'b0;
            countdown       <= '0;
            pending_corpses <= '0;
            on_call         <= 1'b0;
            busy            <= 1'b0;
        end else begin
            state           <= state_nxt;
            frame_q         <= frame_clk;
            countdown       <= cd_nxt;
            pending_corpses <= pend_nxt;
            on_call         <= on_call_nxt;
            busy            <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_police_dispatch.sv
// Bench for police_dispatch: directed scenarios with literal expectations,
// then random traffic, all compared every cycle against a behavioural model.
module tb_police_dispatch;

    localparam int DLY  = 3;
    localparam int COOL = 2;
    localparam int TW   = 10;
    localparam int CW   = 4;
    localparam int PMAX = (1 << CW) - 1;

    localparam int S_IDLE = 0;
    localparam int S_REP  = 1;
    localparam int S_DISP = 2;
    localparam int S_COOL = 3;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          frame_clk = 1'b0;
    logic          corpse_found = 1'b0;
    logic          complete = 1'b0;
    logic          witness_call = 1'b0;
    logic          on_call;
    logic [CW-1:0] pending_corpses;
    logic [TW-1:0] countdown;
    logic          busy;

    int n_chk = 0;
    int n_err = 0;

    police_dispatch #(
        .DISPATCH_DELAY(DLY),
        .COOLDOWN(COOL),
        .TIMER_W(TW),
        .CNT_W(CW)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .frame_clk(frame_clk),
        .corpse_found(corpse_found),
        .complete(complete),
`ifdef POLICE_WITNESS_EN
        .witness_call(witness_call),
`endif
        .on_call(on_call),
        .pending_corpses(pending_corpses),
        .countdown(countdown),
        .busy(busy)
    );

    always #5 Clk = ~Clk;

    // Behavioural model: phase, frames remaining, pending count, last frame level.
    typedef struct {
        int st;
        int cd;
        int pend;
        bit fq;
    } mdl_t;

    mdl_t m = '{S_IDLE, 0, 0, 1'b0};

    function automatic mdl_t mdl_step(mdl_t s, bit fc, bit cf, bit cp, bit wt);
        mdl_t n = s;
        bit tk  = fc && !s.fq;
        bit wit = 1'b0;
        int np;
`ifdef POLICE_WITNESS_EN
        wit = wt && (s.st == S_IDLE || s.st == S_REP);
`endif
        n.fq = fc;
        np = (s.st == S_DISP && cp) ? 0 : s.pend;
        np = np + int'(cf) + int'(wit);
        if (np > PMAX) np = PMAX;
        case (s.st)
            S_IDLE: begin
                if (wit) begin n.st = S_DISP; n.cd = 0; end
                else if (cf) begin n.st = S_REP; n.cd = (DLY < 1) ? 1 : DLY; end
            end
            S_REP: begin
                if (wit) begin n.st = S_DISP; n.cd = 0; end
                else if (tk) begin
                    if (s.cd <= 1) begin n.st = S_DISP; n.cd = 0; end
                    else n.cd = s.cd - 1;
                end
            end
            S_DISP: begin
                if (cp) begin n.st = S_COOL; n.cd = COOL; end
            end
            default: begin
                if (tk) begin
                    if (s.cd <= 1) begin
                        if (np > 0) begin n.st = S_REP; n.cd = (DLY < 1) ? 1 : DLY; end
                        else begin n.st = S_IDLE; n.cd = 0; end
                    end else n.cd = s.cd - 1;
                end
            end
        endcase
        n.pend = np;
        return n;
    endfunction

    always @(posedge Clk or posedge Reset) begin
        if (Reset) m <= '{S_IDLE, 0, 0, 1'b0};
        else       m <= mdl_step(m, frame_clk, corpse_found, complete, witness_call);
    end

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge Clk) begin
        if (!Reset) begin
            check("cmp_on_call", int'(on_call), int'(m.st == S_DISP));
            check("cmp_busy", int'(busy), int'(m.st != S_IDLE));
            check("cmp_countdown", int'(countdown), m.cd);
            check("cmp_pending", int'(pending_corpses), m.pend);
        end
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse_corpse();
        corpse_found = 1'b1; cyc(); corpse_found = 1'b0;
    endtask

    task automatic pulse_complete();
        complete = 1'b1; cyc(); complete = 1'b0;
    endtask

    task automatic frame_tick();
        frame_clk = 1'b1; cyc(); frame_clk = 1'b0; cyc();
    endtask

    initial begin
        cyc(); cyc();
        Reset = 1'b0;
        cyc();
        check("reset_on_call", int'(on_call), 0);
        check("reset_pending", int'(pending_corpses), 0);
        check("reset_countdown", int'(countdown), 0);
        check("reset_busy", int'(busy), 0);

        // Report then three frames to dispatch.
        pulse_corpse();
        check("rep_countdown3", int'(countdown), 3);
        check("rep_pending1", int'(pending_corpses), 1);
        check("rep_busy", int'(busy), 1);
        frame_tick();
        check("rep_countdown2", int'(countdown), 2);
        frame_tick();
        check("rep_countdown1", int'(countdown), 1);
        frame_tick();
        check("disp_on_call", int'(on_call), 1);
        check("disp_countdown0", int'(countdown), 0);

        // Sweep done, cooldown back to idle.
        pulse_complete();
        check("cool_on_call", int'(on_call), 0);
        check("cool_pending", int'(pending_corpses), 0);
        check("cool_countdown", int'(countdown), 2);
        frame_tick();
        frame_tick();
        check("idle_busy", int'(busy), 0);
        check("idle_countdown", int'(countdown), 0);

        // Report during cooldown re-dispatches.
        pulse_corpse();
        repeat (3) frame_tick();
        pulse_complete();
        pulse_corpse();
        check("cool_rep_pending", int'(pending_corpses), 1);
        frame_tick();
        frame_tick();
        check("redo_countdown3", int'(countdown), 3);
        check("redo_on_call0", int'(on_call), 0);
        repeat (3) frame_tick();
        check("redo_on_call1", int'(on_call), 1);

        // Complete and report together: clear then count.
        complete = 1'b1; corpse_found = 1'b1; cyc();
        complete = 1'b0; corpse_found = 1'b0;
        check("both_pending", int'(pending_corpses), 1);
        check("both_countdown", int'(countdown), 2);
        check("both_on_call", int'(on_call), 0);

        // Saturation.
        repeat (20) pulse_corpse();
        check("sat_pending", int'(pending_corpses), 15);
        repeat (6) frame_tick();
        check("sat_on_call", int'(on_call), 1);
        pulse_complete();
        frame_tick();
        frame_tick();
        check("back_idle", int'(busy), 0);

        // Complete while idle does nothing.
        pulse_complete();
        check("idle_cp_busy", int'(busy), 0);
        check("idle_cp_pending", int'(pending_corpses), 0);
        check("idle_cp_on_call", int'(on_call), 0);

`ifdef POLICE_WITNESS_EN
        pulse_corpse();
        frame_tick();
        check("wit_pre_cd", int'(countdown), 2);
        witness_call = 1'b1; cyc(); witness_call = 1'b0;
        check("wit_on_call", int'(on_call), 1);
        check("wit_pending", int'(pending_corpses), 2);
        pulse_complete();
        frame_tick();
        frame_tick();
`endif

        // Asynchronous reset while dispatched.
        pulse_corpse();
        repeat (3) frame_tick();
        check("pre_rst_on_call", int'(on_call), 1);
        #1 Reset = 1'b1;
        #1;
        check("arst_on_call", int'(on_call), 0);
        check("arst_pending", int'(pending_corpses), 0);
        check("arst_busy", int'(busy), 0);
        cyc();
        Reset = 1'b0;
        cyc();

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            corpse_found = ($urandom_range(0, 9) == 0);
            complete     = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 2) == 0) frame_clk = ~frame_clk;
`ifdef POLICE_WITNESS_EN
            witness_call = ($urandom_range(0, 29) == 0);
`endif
            if ($urandom_range(0, 799) == 0) begin
                Reset = 1'b1; cyc(); Reset = 1'b0;
            end
            cyc();
        end
        corpse_found = 1'b0; complete = 1'b0; witness_call = 1'b0;
        cyc(); cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
